// File: rtl/se_arbiter.sv
// se_arbiter: round-robin share of one combinational signal extender between
// decode immediates (requester 0) and the load/store offset path (requester 1).
// The winner's immediate and mode drive the extender; its 32-bit result is
// captured into a single output register tagged with the requester ID.
module se_arbiter #(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic        req0_mode,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic        req1_mode,

  output logic [15:0] se_in,
  output logic        se_op,
  input  logic [31:0] se_out,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data
);

  // Result register and round-robin pointer.
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q,    resp_id_d;
  logic [31:0] resp_data_q,  resp_data_d;
  logic        last_q,       last_d;

  // Arbitration decision for this cycle.
  logic        can_accept;
  logic        gnt0;
  logic        gnt1;
  logic        gnt_any;
  logic        gnt_id;

  // Requester 0 wins when it is alone or when requester 1 was served last;
  // requester 1 is the mirror image. Data never enters this decision.
  function automatic logic wins0(input logic v0, input logic v1, input logic last);
    return v0 && (!v1 || last);
  endfunction

  function automatic logic wins1(input logic v0, input logic v1, input logic last);
    return v1 && (!v0 || !last);
  endfunction

  // Single-entry output buffer: a draining result frees the slot this cycle.
  always_comb begin
    can_accept = !resp_valid_q || resp_ready;
    gnt0       = can_accept && wins0(req0_valid, req1_valid, last_q);
    gnt1       = can_accept && wins1(req0_valid, req1_valid, last_q);
    gnt_any    = gnt0 || gnt1;
    gnt_id     = gnt1;
  end

  // Steer the winner onto the extender; park its inputs at zero when idle.
  always_comb begin
    se_in = 16'h0000;
    se_op = 1'b0;
    if (gnt0) begin
      se_in = req0_data;
      se_op = req0_mode;
    end else if (gnt1) begin
      se_in = req1_data;
      se_op = req1_mode;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next state: capture on grant (replacing any draining result), clear on
  // drain without a new grant, otherwise hold.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    last_d       = last_q;
    if (gnt_any) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_id;
      resp_data_d  = se_out;
      last_d       = gnt_id;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State update; reset discards any pending result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
      last_q       <= RESET_LAST;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      last_q       <= last_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_se_arbiter.sv
// Directed bench for se_arbiter with a behavioural signal extender attached.
module tb_se_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_mode;
  logic [15:0] req0_data;
  logic        req1_valid, req1_ready, req1_mode;
  logic [15:0] req1_data;
  logic [15:0] se_in;
  logic        se_op;
  logic [31:0] se_out;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  int checks   = 0;
  int failures = 0;

  se_arbiter #(.RESET_LAST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_mode  (req1_mode),
    .se_in      (se_in),
    .se_op      (se_op),
    .se_out     (se_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  // External extender: mode 0 sign-extends bit 11, mode 1 sign-extends bit 15.
  assign se_out = se_op ? {{16{se_in[15]}}, se_in} : {{20{se_in[11]}}, se_in[11:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge; combinational checks follow #1 later.
  task automatic drive(input logic v0, input logic [15:0] d0, input logic m0,
                       input logic v1, input logic [15:0] d1, input logic m1,
                       input logic rr);
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_mode = m0;
    req1_valid = v1; req1_data = d1; req1_mode = m1;
    resp_ready = rr;
    #1;
  endtask

  // Advance past the next rising edge for registered checks.
  task automatic edge_pass();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = 16'h0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_data = 16'h0; req1_mode = 1'b0;
    resp_ready = 1'b0;

    // Reset state; readies stay valid-driven while in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_id",    {31'b0, resp_id},    32'd0);
    check("rst_resp_data",  resp_data,           32'h0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // req0, mode 0, negative 12-bit value
    drive(1'b1, 16'h0800, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("s0_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("s0_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("s0_se_in",      {16'b0, se_in},      32'h0800);
    check("s0_se_op",      {31'b0, se_op},      32'd0);
    edge_pass();
    check("s0_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("s0_resp_id",    {31'b0, resp_id},    32'd0);
    check("s0_resp_data",  resp_data,           32'hFFFFF800);

    // req0, mode 0, upper nibble ignored
    drive(1'b1, 16'hF7FF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    edge_pass();
    check("s1_resp_data",  resp_data,           32'h000007FF);

    // req1, mode 1, negative and positive 16-bit values
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
    check("s2_req1_ready", {31'b0, req1_ready}, 32'd1);
    check("s2_se_op",      {31'b0, se_op},      32'd1);
    edge_pass();
    check("s2_resp_id",    {31'b0, resp_id},    32'd1);
    check("s2_resp_data",  resp_data,           32'hFFFF8000);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    edge_pass();
    check("s3_resp_id",    {31'b0, resp_id},    32'd1);
    check("s3_resp_data",  resp_data,           32'h00007FFF);

    // Both valid, last grant was requester 1: ids 0,1,0,1
    drive(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1);
    check("rr0_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("rr0_req1_ready", {31'b0, req1_ready}, 32'd0);
    edge_pass();
    check("rr0_id",   {31'b0, resp_id}, 32'd0);
    check("rr0_data", resp_data,        32'h00000001);
    #1;
    check("rr1_req1_ready", {31'b0, req1_ready}, 32'd1);
    check("rr1_req0_ready", {31'b0, req0_ready}, 32'd0);
    edge_pass();
    check("rr1_id",   {31'b0, resp_id}, 32'd1);
    check("rr1_data", resp_data,        32'h00000002);
    edge_pass();
    check("rr2_id",   {31'b0, resp_id}, 32'd0);
    check("rr2_valid", {31'b0, resp_valid}, 32'd1);
    edge_pass();
    check("rr3_id",   {31'b0, resp_id}, 32'd1);
    check("rr3_data", resp_data,        32'h00000002);

    // Backpressure for 3 cycles with req0 pending
    drive(1'b1, 16'h0123, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
      check("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      check("bp_se_in",      {16'b0, se_in},      32'h0);
      edge_pass();
      check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_resp_id",    {31'b0, resp_id},    32'd1);
      check("bp_resp_data",  resp_data,           32'h00000002);
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, req0_ready}, 32'd1);
    edge_pass();
    check("bp_new_valid", {31'b0, resp_valid}, 32'd1);
    check("bp_new_id",    {31'b0, resp_id},    32'd0);
    check("bp_new_data",  resp_data,           32'h00000123);

    // Asynchronous reset with a pending result
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, resp_valid}, 32'd0);
    check("arst_data",  resp_data,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0FFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    check("arst_req0_ready", {31'b0, req0_ready}, 32'd1);
    check("arst_req1_ready", {31'b0, req1_ready}, 32'd0);
    edge_pass();
    check("arst_grant_id",   {31'b0, resp_id},    32'd0);
    check("arst_grant_data", resp_data,           32'hFFFFFFFF);

    // Idle: extender inputs parked, result drains
    drive(1'b0, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
    check("idle_se_in",   {16'b0, se_in},      32'h0);
    check("idle_se_op",   {31'b0, se_op},      32'd0);
    check("idle_ready0",  {31'b0, req0_ready}, 32'd0);
    check("idle_ready1",  {31'b0, req1_ready}, 32'd0);
    edge_pass();
    check("idle_drained", {31'b0, resp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
